// File: rtl/des_56_job_sequencer_if.sv
// Job-in and result-out handshake bundle for the des_56 job sequencer.
// The master side offers jobs and accepts results, the slave side is the sequencer.
interface des_56_job_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic [55:0] in_state;
   logic [55:0] in_key;
   logic        res_valid;
   logic        res_ready;
   logic [55:0] res_data;

   modport master (
      output in_valid, in_state, in_key, res_ready,
      input  in_ready, res_valid, res_data
   );

   modport slave (
      input  in_valid, in_state, in_key, res_ready,
      output in_ready, res_valid, res_data
   );
endinterface

// File: rtl/des_56_job_sequencer.sv
// Upstream sequencer for the des_56 core: buffers (state, key) jobs in a small
// FIFO, launches them one at a time with a single-cycle start pulse, collects
// the result on the core's out_valid level and hands it downstream with
// backpressure. A watchdog drops a job if the core never answers.
module des_56_job_sequencer #(
   parameter int FIFO_DEPTH = 2,
   parameter int TIMEOUT    = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   des_56_job_sequencer_if.slave bus,
   output logic                 o_core_start,
   output logic [55:0]          o_core_state,
   output logic [55:0]          o_core_key,
   input  logic [55:0]          i_core_out,
   input  logic                 i_core_out_valid,
   output logic                 o_busy,
   output logic                 o_timeout_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int WW = $clog2(TIMEOUT);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
   localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2
   } state_t;

   logic [55:0]   r_fifo_state [FIFO_DEPTH];
   logic [55:0]   r_fifo_key   [FIFO_DEPTH];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;
   logic          r_in_ready;
   state_t        r_state;
   logic          r_core_start;
   logic [55:0]   r_core_state;
   logic [55:0]   r_core_key;
   logic          r_res_valid;
   logic [55:0]   r_res_data;
   logic          r_timeout_err;
   logic [WW-1:0] r_wd;

   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_slot_free;
   logic [AW:0]   w_wr_nxt;
   logic [AW:0]   w_rd_nxt;
   logic          w_full_nxt;
   logic [WW-1:0] w_wd_inc;

   // Handshake qualifiers and next-pointer arithmetic for the job FIFO.
   always_comb begin
      w_empty     = (r_wr_ptr == r_rd_ptr);
      w_push      = bus.in_valid & r_in_ready;
      w_pop       = (r_state == S_IDLE) & ~w_empty;
      w_slot_free = ~r_res_valid | bus.res_ready;
      w_wr_nxt    = r_wr_ptr + {{AW{1'b0}}, w_push};
      w_rd_nxt    = r_rd_ptr + {{AW{1'b0}}, w_pop};
      w_full_nxt  = ((w_wr_nxt - w_rd_nxt) == FULL_CNT);
      w_wd_inc    = r_wd + {{(WW - 1){1'b0}}, 1'b1};
   end

   // Job storage; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_state[r_wr_ptr[AW-1:0]] <= bus.in_state;
         r_fifo_key[r_wr_ptr[AW-1:0]]   <= bus.in_key;
      end
   end

   // FIFO pointers, launch FSM, result slot and watchdog.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_in_ready    <= 1'b0;
         r_state       <= S_IDLE;
         r_core_start  <= 1'b0;
         r_core_state  <= 56'd0;
         r_core_key    <= 56'd0;
         r_res_valid   <= 1'b0;
         r_res_data    <= 56'd0;
         r_timeout_err <= 1'b0;
         r_wd          <= '0;
      end else begin
         r_wr_ptr   <= w_wr_nxt;
         r_rd_ptr   <= w_rd_nxt;
         r_in_ready <= ~w_full_nxt;

         // Downstream took the result; a capture below may refill the slot.
         if (r_res_valid & bus.res_ready) begin
            r_res_valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               r_core_start <= 1'b0;
               if (w_pop) begin
                  r_core_state <= r_fifo_state[r_rd_ptr[AW-1:0]];
                  r_core_key   <= r_fifo_key[r_rd_ptr[AW-1:0]];
                  r_core_start <= 1'b1;
                  r_state      <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               // out_valid may still be high from the previous job, so it is ignored here.
               r_core_start <= 1'b0;
               r_wd         <= '0;
               r_state      <= S_WAIT;
            end
            S_WAIT: begin
               r_core_start <= 1'b0;
               if (i_core_out_valid) begin
                  if (w_slot_free) begin
                     r_res_data  <= i_core_out;
                     r_res_valid <= 1'b1;
                     r_state     <= S_IDLE;
                  end
               end else begin
                  r_wd <= w_wd_inc;
                  if (w_wd_inc == WD_LIMIT) begin
                     r_timeout_err <= 1'b1;
                     r_state       <= S_IDLE;
                  end
               end
            end
            default: begin
               r_core_start <= 1'b0;
               r_state      <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.res_valid = r_res_valid;
   assign bus.res_data  = r_res_data;
   assign o_core_start  = r_core_start;
   assign o_core_state  = r_core_state;
   assign o_core_key    = r_core_key;
   assign o_timeout_err = r_timeout_err;
   assign o_busy        = (r_state != S_IDLE) | ~w_empty | r_res_valid;

endmodule

// File: tb/tb_des_56_job_sequencer.sv
// Bench for des_56_job_sequencer: a behavioural des_56 stub answers each start
// 16 cycles later, a job table drives the input port, and a scoreboard checks
// launches and results in order plus the multi-cycle corner cases.
module tb_des_56_job_sequencer;
   localparam int FIFO_DEPTH = 2;
   localparam int TIMEOUT    = 32;

   typedef struct {
      logic [55:0] st;
      logic [55:0] ky;
      logic [55:0] exp;
      bit          want;
   } job_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        core_start;
   logic [55:0] core_state;
   logic [55:0] core_key;
   logic [55:0] core_out;
   logic        core_out_valid;
   logic        busy;
   logic        timeout_err;
   bit          core_dead = 1'b0;

   des_56_job_sequencer_if u_if ();

   des_56_job_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk              (clk),
      .rst              (rst),
      .bus              (u_if.slave),
      .o_core_start     (core_start),
      .o_core_state     (core_state),
      .o_core_key       (core_key),
      .i_core_out       (core_out),
      .i_core_out_valid (core_out_valid),
      .o_busy           (busy),
      .o_timeout_err    (timeout_err)
   );

   always #5 clk = ~clk;

   function automatic logic [55:0] ref_out(logic [55:0] s, logic [55:0] k);
      return {s[27:0], s[55:28]} ^ k ^ 56'h5A_A55A_A55A_A55A;
   endfunction

   // des_56 stub: out_valid drops on start, rises 16 cycles later and holds.
   logic [4:0]  m_cnt;
   logic        m_run;
   logic [55:0] m_s, m_k;
   always @(posedge clk) begin
      if (rst) begin
         core_out_valid <= 1'b0;
         core_out       <= 56'd0;
         m_run          <= 1'b0;
         m_cnt          <= 5'd0;
      end else if (core_start) begin
         core_out_valid <= 1'b0;
         m_run          <= !core_dead;
         m_cnt          <= 5'd1;
         m_s            <= core_state;
         m_k            <= core_key;
      end else if (m_run) begin
         m_cnt <= m_cnt + 5'd1;
         if (m_cnt == 5'd15) begin
            core_out_valid <= 1'b1;
            core_out       <= ref_out(m_s, m_k);
            m_run          <= 1'b0;
         end
      end
   end

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   job_t        vecs[10];
   job_t        cur;
   job_t        launch_q[$];
   logic [55:0] sb_q[$];
   int          launch_cyc[$];
   int          rv_rise[$];
   bit          pushed;
   int          push_cyc;
   bit          prev_rv, prev_hold, prev_start;
   logic [55:0] held;

   task automatic check(string name, logic [55:0] act, logic [55:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic fail_now(string name);
      n_vec++;
      n_err++;
      $display("FAIL %s @cyc %0d", name, cyc);
   endtask

   task automatic monitor();
      job_t j;
      if (!rst) begin
         if (u_if.in_valid && u_if.in_ready) begin
            launch_q.push_back(cur);
            if (cur.want) sb_q.push_back(cur.exp);
            pushed   = 1'b1;
            push_cyc = cyc;
         end
         if (core_start) begin
            launch_cyc.push_back(cyc);
            if (prev_start) fail_now("start_not_single_pulse");
            if (launch_q.size() == 0) begin
               fail_now("spurious_start");
            end else begin
               j = launch_q.pop_front();
               check("core_state", core_state, j.st);
               check("core_key", core_key, j.ky);
            end
         end
         if (u_if.res_valid && !prev_rv) rv_rise.push_back(cyc);
         if (prev_hold && u_if.res_valid) check("res_hold", u_if.res_data, held);
         if (u_if.res_valid && u_if.res_ready) begin
            if (sb_q.size() == 0) fail_now("unexpected_result");
            else check("res_data", u_if.res_data, sb_q.pop_front());
         end
      end
      prev_start = core_start;
      prev_hold  = u_if.res_valid && !u_if.res_ready;
      held       = u_if.res_data;
      prev_rv    = u_if.res_valid;
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_until(int c);
      while (cyc < c) tick();
   endtask

   task automatic send(job_t j, output int at);
      int n = 0;
      cur             = j;
      u_if.in_valid   = 1'b1;
      u_if.in_state   = j.st;
      u_if.in_key     = j.ky;
      pushed          = 1'b0;
      while (!pushed && n < 200) begin
         tick();
         n++;
      end
      if (!pushed) fail_now("push_timeout");
      u_if.in_valid = 1'b0;
      at = push_cyc;
   endtask

   task automatic drain(int max);
      int n = 0;
      while (sb_q.size() != 0 && n < max) begin
         tick();
         n++;
      end
      if (sb_q.size() != 0) fail_now("drain_timeout");
   endtask

   task automatic check_all_zero(string tag);
      check({tag, "_in_ready"}, 56'(u_if.in_ready), 56'd0);
      check({tag, "_core_start"}, 56'(core_start), 56'd0);
      check({tag, "_core_state"}, core_state, 56'd0);
      check({tag, "_core_key"}, core_key, 56'd0);
      check({tag, "_res_valid"}, 56'(u_if.res_valid), 56'd0);
      check({tag, "_res_data"}, u_if.res_data, 56'd0);
      check({tag, "_timeout_err"}, 56'(timeout_err), 56'd0);
      check({tag, "_busy"}, 56'(busy), 56'd0);
   endtask

   initial begin
      int a, l;
      vecs[0] = '{st: 56'h00_1122_3344_5566, ky: 56'hAB_CDEF_0123_4567, exp: 56'd0, want: 1'b1};
      vecs[1] = '{st: 56'hFF_FFFF_FFFF_FFFF, ky: 56'h00_0000_0000_0000, exp: 56'd0, want: 1'b1};
      vecs[2] = '{st: 56'h00_0000_0000_0001, ky: 56'h80_0000_0000_0000, exp: 56'd0, want: 1'b1};
      vecs[3] = '{st: 56'h12_3456_789A_BCDE, ky: 56'hFE_DCBA_9876_5432, exp: 56'd0, want: 1'b1};
      vecs[4] = '{st: 56'hA5_A5A5_A5A5_A5A5, ky: 56'h5A_5A5A_5A5A_5A5A, exp: 56'd0, want: 1'b1};
      vecs[5] = '{st: 56'h0F_0F0F_0F0F_0F0F, ky: 56'h33_3333_3333_3333, exp: 56'd0, want: 1'b1};
      vecs[6] = '{st: 56'hDE_ADBE_EFDE_ADBE, ky: 56'h11_1111_1111_1111, exp: 56'd0, want: 1'b0};
      vecs[7] = '{st: 56'hCA_FEBA_BECA_FEBA, ky: 56'h22_2222_2222_2222, exp: 56'd0, want: 1'b0};
      vecs[8] = '{st: 56'h01_0203_0405_0607, ky: 56'h08_090A_0B0C_0D0E, exp: 56'd0, want: 1'b0};
      vecs[9] = '{st: 56'h77_6655_4433_2211, ky: 56'h99_8877_6655_4433, exp: 56'd0, want: 1'b1};
      for (int i = 0; i < 10; i++) vecs[i].exp = ref_out(vecs[i].st, vecs[i].ky);

      u_if.in_valid  = 1'b0;
      u_if.in_state  = 56'd0;
      u_if.in_key    = 56'd0;
      u_if.res_ready = 1'b1;
      @(posedge clk);
      #1;
      tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();
      check("in_ready_after_reset", 56'(u_if.in_ready), 56'd1);

      // Single job: launch at A+2, result at A+19, idle afterwards.
      send(vecs[0], a);
      check("start_low_A1", 56'(core_start), 56'(0));
      wait_until(a + 2);
      check("start_high_A2", 56'(core_start), 56'd1);
      wait_until(a + 18);
      check("res_valid_low_A18", 56'(u_if.res_valid), 56'd0);
      check("busy_A18", 56'(busy), 56'd1);
      wait_until(a + 19);
      check("res_valid_A19", 56'(u_if.res_valid), 56'd1);
      check("res_data_A19", u_if.res_data, vecs[0].exp);
      tick();
      check("busy_after_accept", 56'(busy), 56'd0);

      // Burst of three back-to-back jobs: FIFO fills, launches 18 cycles apart.
      launch_cyc.delete();
      for (int i = 1; i <= 3; i++) begin
         send(vecs[i], l);
         if (i == 1) a = l;
      end
      check("burst_push_spacing", 56'(l - a), 56'd2);
      check("burst_in_ready_full", 56'(u_if.in_ready), 56'd0);
      drain(120);
      check("burst_launches", 56'(launch_cyc.size()), 56'd3);
      if (launch_cyc.size() == 3) begin
         check("burst_gap1", 56'(launch_cyc[1] - launch_cyc[0]), 56'd18);
         check("burst_gap2", 56'(launch_cyc[2] - launch_cyc[1]), 56'd18);
      end
      tick();

      // Backpressure across two jobs: second waits in WAIT without re-launch or timeout.
      launch_cyc.delete();
      u_if.res_ready = 1'b0;
      send(vecs[4], a);
      send(vecs[5], l);
      repeat (100) tick();
      check("bp_launches", 56'(launch_cyc.size()), 56'd2);
      check("bp_res_valid", 56'(u_if.res_valid), 56'd1);
      check("bp_res_held", u_if.res_data, vecs[4].exp);
      check("bp_no_timeout", 56'(timeout_err), 56'd0);
      check("bp_busy", 56'(busy), 56'd1);
      u_if.res_ready = 1'b1;
      drain(10);
      tick();
      check("bp_done_valid", 56'(u_if.res_valid), 56'd0);
      check("bp_done_timeout", 56'(timeout_err), 56'd0);

      // Mid-operation reset with one job still queued.
      send(vecs[6], a);
      send(vecs[7], l);
      wait_until(a + 8);
      check("mid_busy", 56'(busy), 56'd1);
      rst = 1'b1;
      tick();
      check_all_zero("midrst");
      launch_q.delete();
      sb_q.delete();
      launch_cyc.delete();
      rv_rise.delete();
      rst = 1'b0;
      repeat (60) tick();
      check("midrst_no_launch", 56'(launch_cyc.size()), 56'd0);
      check("midrst_no_result", 56'(rv_rise.size()), 56'd0);

      // Watchdog: dead core drops the first job, the queued one runs normally.
      launch_cyc.delete();
      core_dead = 1'b1;
      send(vecs[8], a);
      send(vecs[9], l);
      l = a + 2;
      wait_until(l + 1);
      check("wd_launch_cycle", 56'(launch_cyc.size() > 0 ? launch_cyc[0] : -1), 56'(l));
      core_dead = 1'b0;
      wait_until(l + TIMEOUT - 1);
      check("wd_err_early", 56'(timeout_err), 56'd0);
      wait_until(l + TIMEOUT);
      check("wd_err_set", 56'(timeout_err), 56'd1);
      wait_until(l + TIMEOUT + 1);
      check("wd_next_launch", 56'(core_start), 56'd1);
      drain(40);
      repeat (5) tick();
      check("wd_err_sticky", 56'(timeout_err), 56'd1);
      rst = 1'b1;
      tick();
      check("wd_err_cleared", 56'(timeout_err), 56'd0);
      rst = 1'b0;
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/des_56_job_sequencer.md
Name: des_56_job_sequencer

Overview:
- Upstream sequencer for the des_56 core.
- Accepts (state, key) jobs on a valid/ready input port and buffers them in a small FIFO.
- Issues one job at a time to the core as a single-cycle start pulse, with state and key held stable.
- Waits for the core's out_valid level, then presents the result on a valid/ready output port with backpressure. A watchdog guards against a hung core.

Parameters:
- FIFO_DEPTH, 2, input job FIFO depth; power of two, at least 2.
- TIMEOUT, 32, maximum WAIT cycles before a job is dropped; must be greater than 16.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  job offered.
- in_ready  out  1  FIFO can accept a job.
- in_state  in  56  job data block.
- in_key  in  56  job key.
- core_start  out  1  to des_56 start.
- core_state  out  56  to des_56 state.
- core_key  out  56  to des_56 key.
- core_out  in  56  from des_56 out.
- core_out_valid  in  1  from des_56 out_valid; a level, not a pulse.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts the result.
- res_data  out  56  result block.
- busy  out  1  FSM not in IDLE, or FIFO non-empty, or res_valid high.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst=1 at a posedge) sets every output to 0 on the next cycle:
  - in_ready=0 during the reset cycle, then 1.
  - core_start=0, core_state=0, core_key=0, res_valid=0, res_data=0, timeout_err=0.
  - FIFO flushed, FSM to IDLE, watchdog counter to 0.
- Reset mid-operation abandons the in-flight job with no result. The core shares rst, so both restart clean.
- FIFO behaviour:
  - Push when in_valid & in_ready.
  - in_ready = !full, computed from registered pointers only.
  - A push while full is not possible, since in_ready=0.
  - No bypass: a job pushed in cycle A is visible to the FSM in cycle A+1.
  - A simultaneous push and pop is allowed at any occupancy below full.
  - Pointers wrap modulo FIFO_DEPTH; full and empty are distinguished by an extra pointer bit.
- FSM states: IDLE, LAUNCH, WAIT.
  - IDLE:
    - core_start=0.
    - If the FIFO is non-empty: pop the head into core_state/core_key registers and go to LAUNCH.
  - LAUNCH (exactly 1 cycle):
    - core_start=1.
    - core_out_valid is ignored, because it may still be high from the previous job.
    - Watchdog cleared to 0.
    - Next state is WAIT.
  - WAIT:
    - core_start=0; the watchdog increments each cycle.
    - If core_out_valid=1 and the output slot is free (res_valid=0 or res_ready=1 this cycle): load res_data<=core_out, set res_valid=1, go to IDLE.
    - If core_out_valid=1 and the slot is not free: stay in WAIT with the watchdog frozen. The core holds its out and out_valid while no new start is issued.
    - If core_out_valid=0 and the watchdog reaches TIMEOUT-1: set timeout_err=1, drop the job, go to IDLE.
- core_state/core_key change only on the pop in IDLE and are held through LAUNCH and WAIT.
- Because core_start is low in IDLE and WAIT, every LAUNCH is a clean rising edge for the core's edge detector.
- Output port:
  - res_valid falls on the cycle after res_valid & res_ready, unless a new capture occurs in that same cycle, in which case it stays 1 with new data.
  - res_data is stable while res_valid=1 and res_ready=0.
- timeout_err is sticky until rst.
- Timing, with the core launching at cycle L:
  - core_out_valid is high from L+16.
  - res_valid is high from L+17.
  - Input handshake at cycle A on an idle block gives LAUNCH at A+2 and res_valid at A+19.
  - Steady-state throughput is 1 job per 18 cycles.

Test Plan:
- Single job: reset, then push state=56'h00_1122_3344_5566, key=56'hAB_CDEF_0123_4567 at cycle A -> core_start high only at A+2 with core_state/core_key equal to the pushed values; res_valid at A+19 with res_data equal to the des_56 reference output; busy falls after res_ready.
- Burst: push 3 jobs back-to-back with FIFO_DEPTH=2 -> in_ready drops after 2 pushes; the third is accepted only after the first pop; LAUNCH pulses are 18 cycles apart; results come out in order.
- Backpressure: hold res_ready=0 across two jobs -> first result held stable; second job stays in WAIT with core_start never re-pulsed; after res_ready=1, both results delivered in order with no timeout_err.
- Stale out_valid: launch job 2 while the core's out_valid is still 1 from job 1 -> no capture during LAUNCH; job 2's result is captured at L+16, not L.
- Watchdog: tie core_out_valid=0 via stub -> timeout_err=1 at LAUNCH+TIMEOUT, FSM returns to IDLE, next FIFO job launches, flag stays 1 until rst.
- Mid-op reset: assert rst in WAIT with 1 job queued -> all outputs 0 next cycle, FIFO empty, no res_valid afterwards.
